// File: rtl/lsu_mmio_pkg.sv
// lsu_mmio_pkg: shared types and constants for the MMIO load/store unit.
// Holds the func3 codes, address regions, split FSM states and the access size.
package lsu_mmio_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } func3_e;

  typedef enum logic [2:0] {
    RG_DMEM,
    RG_LEDR,
    RG_LEDG,
    RG_HEX,
    RG_LCD,
    RG_SW,
    RG_NONE
  } region_e;

  typedef enum logic {
    S_IDLE,
    S_SECOND
  } state_e;

  localparam logic [31:0] DMEM_MASK = 32'h1000_0000;
  localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
  localparam logic [31:0] PAGE_MASK = 32'hFFFF_F000;
  localparam logic [31:0] LEDR_BASE = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE = 32'h1000_1000;
  localparam logic [31:0] HEX_BASE  = 32'h1000_2000;
  localparam logic [31:0] LCD_BASE  = 32'h1000_4000;
  localparam logic [31:0] SW_BASE   = 32'h1001_0000;

  // Bytes touched by an access; illegal codes fall into the word case.
  function automatic logic [2:0] lsu_size(input logic [2:0] f3);
    logic [2:0] s;
    unique case (f3[1:0])
      2'b00:   s = 3'd1;
      2'b01:   s = 3'd2;
      default: s = 3'd4;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// lsu_dmem: single-port data memory, byte-enable sync write, async read.
// Ports: clk_i, addr_i (word index), be_i, wdata_i, we_i -> rdata_o.
module lsu_dmem #(
  parameter int WORDS = 16384,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  input  logic          we_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) begin
        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/lsu_mmio_v2.sv
// lsu_mmio_v2: load/store unit with DMEM, LED/HEX/LCD outputs and switches.
// Ports: i_lsu_* access, i_func3, i_io_sw -> o_ld_data, o_stall, o_err, o_io_*.
module lsu_mmio_v2
  import lsu_mmio_pkg::*;
#(
  parameter int DMEM_WORDS  = 16384,
  parameter int NUM_HEX     = 8,
  parameter int LEDR_W      = 32,
  parameter int LEDG_W      = 32,
  parameter int SW_W        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [31:0]          i_lsu_addr,
  input  logic [31:0]          i_st_data,
  input  logic                 i_lsu_wren,
  input  logic                 i_lsu_rden,
  input  logic [2:0]           i_func3,
  input  logic [SW_W-1:0]      i_io_sw,
  output logic [31:0]          o_ld_data,
  output logic                 o_stall,
  output logic                 o_err,
  output logic [LEDR_W-1:0]    o_io_ledr,
  output logic [LEDG_W-1:0]    o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd
);

  localparam int AW = $clog2(DMEM_WORDS);

  state_e                            state_q;
  logic [31:0]                       lo_q;
  logic [LEDR_W-1:0]                 ledr_q, ledr_d;
  logic [LEDG_W-1:0]                 ledg_q, ledg_d;
  logic [31:0]                       lcd_q, lcd_d;
  logic [15:0][6:0]                  hex_q, hex_d;
  logic [SYNC_STAGES-1:0][SW_W-1:0]  sync_q;

  region_e     rgn;
  logic [31:0] page;
  logic [1:0]  off;
  logic [2:0]  size;
  logic [3:0]  lmask, span;
  logic [7:0]  be8;
  logic [63:0] wd64, src64;
  logic [31:0] wd32, m32, pword, sh, ext;
  logic        acc, bad_f3, periph, mis, illegal, ok;
  logic        split, second, wr_ok;
  logic [AW-1:0] dm_idx;
  logic [31:0] dm_rdata;
  logic [5:0]  rk, wk;

  assign page = i_lsu_addr & PAGE_MASK;

  always_comb begin
    rgn = RG_NONE;
    unique case (1'b1)
      ((i_lsu_addr & DMEM_MASK) == DMEM_BASE): rgn = RG_DMEM;
      (page == LEDR_BASE): rgn = RG_LEDR;
      (page == LEDG_BASE): rgn = RG_LEDG;
      (page == HEX_BASE):  rgn = RG_HEX;
      (page == LCD_BASE):  rgn = RG_LCD;
      (page == SW_BASE):   rgn = RG_SW;
      default:             rgn = RG_NONE;
    endcase
  end

  assign off    = i_lsu_addr[1:0];
  assign size   = lsu_size(i_func3);
  assign lmask  = (size == 3'd1) ? 4'h1 :
                  (size == 3'd2) ? 4'h3 : 4'hF;
  assign span   = {2'b00, off} + {1'b0, size};
  assign acc    = i_lsu_wren | i_lsu_rden;
  assign bad_f3 = (i_func3 == 3'b011) | (i_func3[2:1] == 2'b11);
  assign periph = (rgn != RG_DMEM) && (rgn != RG_NONE);
  assign mis    = periph &
                  (((i_func3[1:0] == 2'b01) & off[0]) |
                   ((i_func3[1:0] == 2'b10) & (off != 2'b00)));
  assign illegal = acc & (bad_f3 | mis);
  assign ok      = acc & ~illegal;
  assign wr_ok   = i_lsu_wren & ok;
  assign second  = (state_q == S_SECOND);
  assign split   = ok & (rgn == RG_DMEM) & (span > 4'd4);

  // 8 lanes span word n and word n+1; the upper half is the SECOND cycle.
  assign be8  = {4'b0000, lmask} << off;
  assign wd64 = {32'b0, i_st_data} << {off, 3'b000};
  assign wd32 = wd64[31:0];

  assign dm_idx = i_lsu_addr[AW+1:2] + AW'(second);

  lsu_dmem #(
    .WORDS (DMEM_WORDS),
    .AW    (AW)
  ) u_dmem (
    .clk_i   (i_clk),
    .addr_i  (dm_idx),
    .be_i    (second ? be8[7:4] : be8[3:0]),
    .wdata_i (second ? wd64[63:32] : wd32),
    .we_i    (i_reset & wr_ok & (rgn == RG_DMEM)),
    .rdata_o (dm_rdata)
  );

  always_comb begin
    pword = '0;
    rk    = '0;
    unique case (rgn)
      RG_LEDR: pword = 32'(ledr_q);
      RG_LEDG: pword = 32'(ledg_q);
      RG_LCD:  pword = lcd_q;
      RG_SW:   pword = 32'(sync_q[SYNC_STAGES-1]);
      RG_HEX: begin
        for (int b = 0; b < 4; b++) begin
          rk = {i_lsu_addr[5:2], 2'(b)};
          if (rk < 6'(NUM_HEX)) begin
            pword[8*b +: 8] = {1'b0, hex_q[rk[3:0]]};
          end
        end
      end
      default: pword = '0;
    endcase
  end

  assign src64 = (rgn != RG_DMEM) ? {32'b0, pword} :
                 second ? {dm_rdata, lo_q} : {32'b0, dm_rdata};
  assign sh    = 32'(src64 >> {off, 3'b000});

  always_comb begin
    unique case (func3_e'(i_func3))
      F3_B:    ext = {{24{sh[7]}}, sh[7:0]};
      F3_H:    ext = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   ext = {24'b0, sh[7:0]};
      F3_HU:   ext = {16'b0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  assign o_ld_data = (i_lsu_rden & ok) ? ext : '0;
  assign o_stall   = i_reset & ~second & split;
  assign o_err     = i_reset & illegal;

  always_comb begin
    m32 = '0;
    for (int b = 0; b < 4; b++) begin
      m32[8*b +: 8] = {8{be8[b]}};
    end
  end

  assign ledr_d = LEDR_W'((32'(ledr_q) & ~m32) | (wd32 & m32));
  assign ledg_d = LEDG_W'((32'(ledg_q) & ~m32) | (wd32 & m32));
  assign lcd_d  = (lcd_q & ~m32) | (wd32 & m32);

  always_comb begin
    hex_d = hex_q;
    wk    = '0;
    if (wr_ok && rgn == RG_HEX) begin
      for (int b = 0; b < 4; b++) begin
        wk = {i_lsu_addr[5:2], 2'(b)};
        if (be8[b] && wk < 6'(NUM_HEX)) begin
          hex_d[wk[3:0]] = wd32[8*b +: 7];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
      hex_q  <= {16{7'h7F}};
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_io_sw};
      hex_q  <= hex_d;
      if (wr_ok && rgn == RG_LEDR) ledr_q <= ledr_d;
      if (wr_ok && rgn == RG_LEDG) ledg_q <= ledg_d;
      if (wr_ok && rgn == RG_LCD)  lcd_q  <= lcd_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (split) begin
            state_q <= S_SECOND;
            if (i_lsu_rden) lo_q <= dm_rdata;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex  = hex_q[NUM_HEX-1:0];

endmodule

// File: tb/tb_lsu_mmio_v2.sv
// tb_lsu_mmio_v2: random + directed bench against a byte-level model.
// Model keeps DMEM as a byte map and peripherals as plain registers.
module tb_lsu_mmio_v2;

  localparam int DW   = 16384;
  localparam int NH   = 8;
  localparam int MEMB = 4 * DW;

  logic            clk;
  logic            rst_n;
  logic [31:0]     addr, st, ld;
  logic            wren, rden;
  logic [2:0]      f3;
  logic [31:0]     sw;
  logic            stall, err;
  logic [31:0]     ledr, ledg, lcd;
  logic [7*NH-1:0] hex;

  lsu_mmio_v2 #(
    .DMEM_WORDS (DW), .NUM_HEX (NH), .LEDR_W (32),
    .LEDG_W (32), .SW_W (32), .SYNC_STAGES (2)
  ) dut (
    .i_clk (clk), .i_reset (rst_n), .i_lsu_addr (addr),
    .i_st_data (st), .i_lsu_wren (wren), .i_lsu_rden (rden),
    .i_func3 (f3), .i_io_sw (sw), .o_ld_data (ld),
    .o_stall (stall), .o_err (err), .o_io_ledr (ledr),
    .o_io_ledg (ledg), .o_io_hex (hex), .o_io_lcd (lcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem_m [int];
  logic [31:0] ledr_m, ledg_m, lcd_m, sw_m;
  logic [6:0]  dig_m [NH];
  int n_chk, n_pass;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [55:0] hex_m();
    logic [55:0] v;
    for (int k = 0; k < NH; k++) v[7*k +: 7] = dig_m[k];
    return v;
  endfunction

  // 0 dmem, 1 ledr, 2 ledg, 3 hex, 4 lcd, 5 sw, 6 unmapped
  function automatic int rgn_of(input logic [31:0] a);
    if (!a[28]) return 0;
    case (a[31:12])
      20'h10000: return 1;
      20'h10001: return 2;
      20'h10002: return 3;
      20'h10004: return 4;
      20'h10010: return 5;
      default:   return 6;
    endcase
  endfunction

  function automatic int dkey(input logic [31:0] a, input int i);
    return ((int'(a) & (MEMB - 1)) + i) % MEMB;
  endfunction

  function automatic logic [7:0] rd_byte(input int rg,
                                         input logic [31:0] a,
                                         input int i);
    int lane, k;
    lane = int'(a[1:0]) + i;
    case (rg)
      0: return mem_m.exists(dkey(a, i)) ? mem_m[dkey(a, i)] : 8'h00;
      1: return ledr_m[8*lane +: 8];
      2: return ledg_m[8*lane +: 8];
      3: begin
        k = 4 * int'(a[5:2]) + lane;
        return (k < NH) ? {1'b0, dig_m[k]} : 8'h00;
      end
      4: return lcd_m[8*lane +: 8];
      5: return sw_m[8*lane +: 8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic reset_model();
    ledr_m = 0; ledg_m = 0; lcd_m = 0;
    for (int k = 0; k < NH; k++) dig_m[k] = 7'h7F;
  endtask

  task automatic chk_outs();
    chk("ledr", ledr, ledr_m);
    chk("ledg", ledg, ledg_m);
    chk("lcd", lcd, lcd_m);
    chk("hex", hex, hex_m());
  endtask

  task automatic acc(input bit we, input bit re, input logic [2:0] fc,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] got);
    int rg, sz, off, lane, k;
    bit bad, mis, e, sp;
    logic [31:0] v;
    logic [7:0]  by;
    rg  = rgn_of(a);
    off = int'(a[1:0]);
    sz  = (fc[1:0] == 0) ? 1 : (fc[1:0] == 1) ? 2 : 4;
    bad = (fc == 3) || (fc >= 6);
    mis = (rg >= 1 && rg <= 5) &&
          ((fc[1:0] == 1 && a[0]) || (fc == 2 && off != 0));
    e   = (we || re) && (bad || mis);
    sp  = !e && (we || re) && rg == 0 && (off + sz > 4);
    v   = 0;
    if (re && !e) begin
      for (int i = 0; i < sz; i++) v[8*i +: 8] = rd_byte(rg, a, i);
      if (!fc[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!fc[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
    end
    @(negedge clk);
    wren = we; rden = re; f3 = fc; addr = a; st = d;
    #1;
    chk("stall", stall, sp);
    chk("err", err, e);
    if (sp) begin
      @(posedge clk);
      #1;
      chk("stall2", stall, 0);
      chk("err2", err, 0);
    end
    got = ld;
    if (!we) chk("ld", ld, v);
    @(posedge clk);
    #1;
    wren = 0; rden = 0;
    if (we && !e) begin
      for (int i = 0; i < sz; i++) begin
        lane = off + i;
        by   = d[8*i +: 8];
        case (rg)
          0: mem_m[dkey(a, i)] = by;
          1: ledr_m[8*lane +: 8] = by;
          2: ledg_m[8*lane +: 8] = by;
          3: begin
            k = 4 * int'(a[5:2]) + lane;
            if (k < NH) dig_m[k] = by[6:0];
          end
          4: lcd_m[8*lane +: 8] = by;
          default: ;
        endcase
      end
    end
    chk_outs();
  endtask

  logic [31:0] r, a;
  logic [2:0]  fc;
  logic [55:0] hx;
  int op, pick;

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 0; wren = 0; rden = 0; f3 = 0; addr = 0; st = 0;
    sw = 32'h1234_5678; sw_m = sw;
    reset_model();
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_err", err, 0);
    chk("rst_ld", ld, 0);
    chk_outs();
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk);

    acc(1, 0, 3'b010, 32'h100, 32'h8899AABB, r);
    acc(0, 1, 3'b000, 32'h103, 0, r);
    chk("lb", r, 32'hFFFFFF88);
    acc(0, 1, 3'b100, 32'h103, 0, r);
    chk("lbu", r, 32'h00000088);

    acc(1, 0, 3'b010, 32'h202, 32'h11223344, r);
    acc(0, 1, 3'b101, 32'h202, 0, r);
    chk("lo_half", r, 32'h3344);
    acc(0, 1, 3'b101, 32'h204, 0, r);
    chk("hi_half", r, 32'h1122);
    acc(0, 1, 3'b010, 32'h202, 0, r);
    chk("lw_split", r, 32'h11223344);

    acc(1, 0, 3'b000, 32'h1000_2005, 32'h3F, r);
    hx = {8{7'h7F}};
    hx[35 +: 7] = 7'h3F;
    chk("hex5", hex, hx);
    acc(0, 1, 3'b010, 32'h1000_2004, 0, r);
    chk("hex_rd", r, 32'h7F7F3F7F);

    acc(1, 0, 3'b001, 32'h1000_0001, 32'hFFFF, r);
    acc(0, 1, 3'b011, 32'h100, 0, r);
    chk("bad_f3_ld", r, 0);

    @(negedge clk);
    sw = 32'hA5; wren = 0; rden = 1; f3 = 3'b010;
    addr = 32'h1001_0000;
    #1 chk("sw_old0", ld, 32'h1234_5678);
    @(posedge clk); #1 chk("sw_old1", ld, 32'h1234_5678);
    @(posedge clk); #1 chk("sw_new", ld, 32'hA5);
    rden = 0; sw_m = 32'hA5;

    for (int w = 0; w < 32; w++) acc(1, 0, 3'b010, 4 * w, $urandom, r);
    acc(1, 0, 3'b010, MEMB - 4, $urandom, r);

    for (int it = 0; it < 400; it++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1: fc = 3'b000;
        2, 3: fc = 3'b001;
        4, 5: fc = 3'b010;
        6:    fc = 3'b100;
        7:    fc = 3'b101;
        8:    fc = 3'b011;
        default: fc = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b110;
      endcase
      pick = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 3));
      case (pick)
        0, 1, 2: a = {4'h0, 12'($urandom), 16'($urandom_range(0, 123))};
        3: a = {4'h0, 12'($urandom), 16'(MEMB - 4)} | a;
        4: a = 32'h1000_0000 | a;
        5: a = 32'h1000_1000 | a;
        6: a = 32'h1000_2000 | (32'($urandom_range(0, 3)) << 2) | a;
        7: a = 32'h1000_4000 | a;
        8: a = 32'h1001_0000 | a;
        default: a = (($urandom_range(0, 1) == 1) ?
                      32'h1000_3000 : 32'h3002_0000) | a;
      endcase
      op = $urandom_range(0, 19);
      if (op < 9)       acc(1, 0, fc, a, $urandom, r);
      else if (op < 18) acc(0, 1, fc, a, 0, r);
      else              acc(0, 0, fc, a, $urandom, r);
    end

    acc(1, 0, 3'b010, 32'h1000_0000, 32'hDEADBEEF, r);
    acc(1, 0, 3'b010, 32'h1000_4000, 32'hCAFEF00D, r);
    acc(1, 0, 3'b010, 32'h300, 32'hAAAAAAAA, r);
    acc(1, 0, 3'b010, 32'h304, 32'h55555555, r);
    @(negedge clk);
    wren = 1; f3 = 3'b010; addr = 32'h302; st = 32'h11223344;
    #1 chk("rs_stall1", stall, 1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    reset_model();
    mem_m[32'h302] = 8'h44;
    mem_m[32'h303] = 8'h33;
    chk("rs_stall", stall, 0);
    chk("rs_err", err, 0);
    chk_outs();
    @(negedge clk); wren = 0;
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk);
    acc(0, 1, 3'b010, 32'h300, 0, r);
    chk("rs_lo", r, 32'h3344AAAA);
    acc(0, 1, 3'b010, 32'h304, 0, r);
    chk("rs_hi", r, 32'h55555555);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_mmio_v2.md
Name: lsu_mmio_v2

Overview:
Parametrised second-generation load/store unit for the single-cycle RV32I core. It decodes each data access into data memory, output peripherals (LEDR, LEDG, a HEX bank of NUM_HEX digits, LCD) or synchronised switch inputs. A loaded value is sign- or zero-extended according to func3, and output registers can be read back. Data-memory accesses that cross a word boundary run as a two-cycle split transaction; o_stall freezes the core for the extra cycle.

Parameters:
DMEM_WORDS, 16384, data-memory depth in 32-bit words (power of two); index width AW = log2(DMEM_WORDS)
NUM_HEX, 8, number of 7-segment digits (1..16), 4 digits per 32-bit register word
LEDR_W, 32, red LED register width (1..32)
LEDG_W, 32, green LED register width (1..32)
SW_W, 32, switch input width (1..32)
SYNC_STAGES, 2, flip-flop stages on i_io_sw (>=2)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  asynchronous, active-low reset
i_lsu_addr  in  32  byte address
i_st_data  in  32  store data, right-aligned
i_lsu_wren  in  1  store request
i_lsu_rden  in  1  load request (never asserted together with i_lsu_wren)
i_func3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
i_io_sw  in  SW_W  asynchronous switches
o_ld_data  out  32  extended load result, combinational
o_stall  out  1  core must hold all inputs stable and not retire
o_err  out  1  single-cycle pulse on an illegal access
o_io_ledr  out  LEDR_W  red LEDs
o_io_ledg  out  LEDG_W  green LEDs
o_io_hex  out  7*NUM_HEX  digit k on bits [7k+6:7k]
o_io_lcd  out  32  LCD control word

Behaviour:
- Decode
  - addr[28]=0: DMEM, word index addr[AW+1:2].
  - 0x1000_0xxx LEDR; 0x1000_1xxx LEDG; 0x1000_2xxx HEX, bank word addr[5:2], byte lane b drives digit 4*word+b (bits [6:0] of the lane); 0x1000_4xxx LCD; 0x1001_0xxx SW, read-only.
  - Anything else is unmapped.
- Byte lanes: for B/BU, H/HU and W, the lanes are byte lane addr[1:0] upward, width 1, 2 or 4 bytes. Store data is shifted to those lanes.
- Aligned DMEM access completes in the same cycle.
  - Load data is combinational from the DMEM read.
  - Store: lanes are written at the clock edge.
- Load extension: selected bytes are shifted down to bit 0. B and H sign-extend; BU, HU and W zero-extend.
- Peripheral stores
  - Only the selected lanes update, at the edge.
  - Lanes above a register's width, and digits >= NUM_HEX, are ignored.
- Peripheral loads return the current register value zero-padded to 32 bits. HEX reads return 4 digits per word, bit 7 of each lane = 0.
- SW load returns the output of the last synchroniser stage, zero-padded.
- Unmapped access: load returns 0, store has no effect, no error.
- Illegal access (o_err=1 for that cycle, no state change, o_ld_data=0, no stall) when either holds:
  - func3 is 011 or 11x;
  - a misaligned access targets a peripheral (H with addr[0]=1, or W with addr[1:0]!=0).
- Split FSM, states IDLE and SECOND. A DMEM access with addr[1:0]+size > 4 is a split access.
  - IDLE, split access:
    - o_stall=1.
    - Load: the lanes from word n are captured into hold register lo_q.
    - Store: the lower-word lanes of word n are written.
    - Next state is SECOND.
  - SECOND:
    - Accesses word n+1, lanes 0..(addr[1:0]+size-5), with o_stall=0.
    - Load: o_ld_data combines lo_q with the upper bytes, then extends.
    - Store: the upper-word lanes are written.
    - Next state is IDLE.
  - Word index n+1 wraps modulo DMEM_WORDS.
  - Inputs change during SECOND: undefined; the core guarantees they are held.
- Reset (async, active-low)
  - State IDLE; o_stall=0; o_err=0; lo_q=0.
  - LEDR, LEDG and LCD = 0; every digit = 7'h7F; synchroniser stages = 0.
  - DMEM contents are not reset.
  - Reset asserted in SECOND abandons the transaction; a first-half store that is already written stays written.
- Simultaneous events: with no wren/rden there are no side effects and o_ld_data=0.

Decomposition:
- Package lsu_mmio_pkg:
  - func3 enum;
  - region base/mask constants (DMEM, LEDR, LEDG, HEX, LCD, SW);
  - FSM state typedef;
  - size-from-func3 function.
- Sub-module lsu_dmem: DMEM_WORDS x 32, byte-enable synchronous write, asynchronous read, one port.

Test Plan:
- SW at 0x0000_0100 data 0x8899AABB, then LB at 0x0000_0103 and LBU at 0x0000_0103 -> LB returns 0xFFFFFF88, LBU returns 0x00000088; no stall.
- SW at 0x0000_0202 data 0x11223344 -> o_stall=1 for one cycle; word 0x200 lanes 2,3 = 0x44,0x33 and word 0x204 lanes 0,1 = 0x22,0x11. Then LW at 0x0000_0202 -> stall for 1 cycle, result 0x11223344.
- SB 0x3F at 0x1000_2005 with NUM_HEX=8 -> digit 5 = 7'h3F, all other digits stay 7'h7F. LW at 0x1000_2004 -> 0x7F7F3F7F.
- SH at 0x1000_0001 -> o_err pulses for 1 cycle; LEDR unchanged; no stall. A func3=011 load -> o_err, o_ld_data=0.
- i_io_sw changes to 0x0000_00A5 -> a load of 0x1001_0000 returns 0xA5 only after SYNC_STAGES edges, and the old value before that.
- Reset pulled low during SECOND of a split store -> state IDLE, o_stall=0, LEDR=0 and hex digits = 7'h7F immediately; the first-half bytes remain in DMEM.
